calc_sequenciador: RTL and testbench

CALC_SEQUENCIADOR -- requirements
Module: calc_sequenciador

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_mem.sv | 33 +++
 rtl/calc_sequenciador.sv | 173 +++++++++++++++++
 tb/tb_calc_sequenciador.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator sequencer.
//   - program word layout: [11] calculator reset, [10:8] codigo, [7:0] entrada
//   - drive values presented to the calculator while nothing is playing
//   - sequencer state encoding
package calc_pkg;

  localparam int WORD_W  = 12;
  localparam int RST_BIT = 11;
  localparam int COD_MSB = 10;
  localparam int COD_LSB = 8;
  localparam int ENT_MSB = 7;
  localparam int ENT_LSB = 0;
  localparam int COD_W   = COD_MSB - COD_LSB + 1;
  localparam int ENT_W   = ENT_MSB - ENT_LSB + 1;
  localparam int RES_W   = 8;

  // Idle drive: calculator held in reset with a neutral opcode/operand.
  localparam logic             IDLE_RESET   = 1'b1;
  localparam logic [COD_W-1:0] IDLE_CODIGO  = '0;
  localparam logic [ENT_W-1:0] IDLE_ENTRADA = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/calc_mem.sv
// calc_mem: small storage array with one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
module calc_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/calc_sequenciador.sv
// calc_sequenciador: plays a stored program of calculator words onto the
// calculator drive pins and records the calculator's registered result for
// each word.
// Ports:
//   clk, reset (async, active-low)
//   prog_we/prog_addr/prog_data - program load port (accepted only when idle)
//   start/len                   - play request, len words (clamped to DEPTH)
//   calc_reset/calc_codigo/calc_entrada - registered calculator drive
//   calc_saida                  - calculator result (registered by calculator)
//   res_addr/res_data           - combinational result readback
//   busy/done                   - playback active / one-cycle completion pulse
module calc_sequenciador
  import calc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              start,
  input  logic [AW:0]       len,
  output logic              calc_reset,
  output logic [COD_W-1:0]  calc_codigo,
  output logic [ENT_W-1:0]  calc_entrada,
  input  logic [RES_W-1:0]  calc_saida,
  input  logic [AW-1:0]     res_addr,
  output logic [RES_W-1:0]  res_data,
  output logic              busy,
  output logic              done
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t            state_reg, state_next;
  // drv_cnt: index of the next word to drive; 0 whenever idle so the
  // program read port already presents word 0 when start arrives.
  logic [AW:0]       drv_cnt_reg, drv_cnt_next;
  logic [AW-1:0]     cap_idx_reg, cap_idx_next;
  logic [AW:0]       len_reg, len_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              calc_reset_reg, calc_reset_next;
  logic [COD_W-1:0]  calc_codigo_reg, calc_codigo_next;
  logic [ENT_W-1:0]  calc_entrada_reg, calc_entrada_next;

  logic              prog_wr;
  logic              res_wr;
  logic [WORD_W-1:0] prog_rdata;
  logic [AW:0]       len_clamped;

  assign len_clamped = (len > DEPTH_W) ? DEPTH_W : len;

  calc_mem #(.WIDTH(WORD_W), .DEPTH(DEPTH), .AW(AW)) u_prog_mem (
    .clk   (clk),
    .we    (prog_wr),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (drv_cnt_reg[AW-1:0]),
    .rdata (prog_rdata)
  );

  calc_mem #(.WIDTH(RES_W), .DEPTH(DEPTH), .AW(AW)) u_res_mem (
    .clk   (clk),
    .we    (res_wr),
    .waddr (cap_idx_reg),
    .wdata (calc_saida),
    .raddr (res_addr),
    .rdata (res_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      drv_cnt_reg      <= '0;
      cap_idx_reg      <= '0;
      len_reg          <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      calc_reset_reg   <= IDLE_RESET;
      calc_codigo_reg  <= IDLE_CODIGO;
      calc_entrada_reg <= IDLE_ENTRADA;
    end else begin
      state_reg        <= state_next;
      drv_cnt_reg      <= drv_cnt_next;
      cap_idx_reg      <= cap_idx_next;
      len_reg          <= len_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      calc_reset_reg   <= calc_reset_next;
      calc_codigo_reg  <= calc_codigo_next;
      calc_entrada_reg <= calc_entrada_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    drv_cnt_next      = drv_cnt_reg;
    cap_idx_next      = cap_idx_reg;
    len_next          = len_reg;
    busy_next         = busy_reg;
    done_next         = 1'b0;
    calc_reset_next   = calc_reset_reg;
    calc_codigo_next  = calc_codigo_reg;
    calc_entrada_next = calc_entrada_reg;
    prog_wr           = 1'b0;
    res_wr            = 1'b0;

    case (state_reg)
      IDLE: begin
        prog_wr = prog_we;
        if (start) begin
          if (len_clamped == '0) begin
            done_next = 1'b1;
          end else begin
            calc_reset_next   = prog_rdata[RST_BIT];
            calc_codigo_next  = prog_rdata[COD_MSB:COD_LSB];
            calc_entrada_next = prog_rdata[ENT_MSB:ENT_LSB];
            drv_cnt_next      = (AW+1)'(1);
            cap_idx_next      = '0;
            len_next          = len_clamped;
            busy_next         = 1'b1;
            state_next        = RUN;
          end
        end
      end

      RUN: begin
        // The calculator registers its result one edge after a word is
        // driven, so the result of word k is stable only in the cycle after
        // edge k+1: captures start once two words have been launched.
        if (drv_cnt_reg >= (AW+1)'(2)) begin
          res_wr       = 1'b1;
          cap_idx_next = cap_idx_reg + AW'(1);
        end
        if (drv_cnt_reg < len_reg) begin
          calc_reset_next   = prog_rdata[RST_BIT];
          calc_codigo_next  = prog_rdata[COD_MSB:COD_LSB];
          calc_entrada_next = prog_rdata[ENT_MSB:ENT_LSB];
          drv_cnt_next      = drv_cnt_reg + (AW+1)'(1);
        end else begin
          calc_reset_next   = IDLE_RESET;
          calc_codigo_next  = IDLE_CODIGO;
          calc_entrada_next = IDLE_ENTRADA;
          state_next        = DRAIN;
        end
      end

      DRAIN: begin
        // Final capture for the last word, then back to idle.
        res_wr       = 1'b1;
        drv_cnt_next = '0;
        cap_idx_next = '0;
        busy_next    = 1'b0;
        done_next    = 1'b1;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign calc_reset   = calc_reset_reg;
  assign calc_codigo  = calc_codigo_reg;
  assign calc_entrada = calc_entrada_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_calc_sequenciador.sv
// tb_calc_sequenciador: randomized scoreboard bench for calc_sequenciador.
// The stimulus pushes the expected drive words, done cycle and result reads
// into queues; an independent monitor pops and compares them every cycle.
// The calculator is stubbed as calc_saida <= calc_entrada.
module tb_calc_sequenciador;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [11:0] IDLE_WORD = 12'h800;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [11:0]   prog_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          calc_reset;
  logic [2:0]    calc_codigo;
  logic [7:0]    calc_entrada;
  logic [7:0]    calc_saida = '0;
  logic [AW-1:0] res_addr = '0;
  logic [7:0]    res_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  // Calculator stub: echoes the operand one edge later.
  always @(posedge clk) calc_saida <= calc_entrada;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  calc_sequenciador #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .start        (start),
    .len          (len),
    .calc_reset   (calc_reset),
    .calc_codigo  (calc_codigo),
    .calc_entrada (calc_entrada),
    .calc_saida   (calc_saida),
    .res_addr     (res_addr),
    .res_data     (res_data),
    .busy         (busy),
    .done         (done)
  );

  // Reference model state
  logic [11:0] prog_model [DEPTH];
  logic [7:0]  res_model  [DEPTH];
  bit          res_known  [DEPTH];

  // Scoreboard queues
  logic [11:0] drive_q[$];
  int          done_q[$];
  logic [7:0]  res_exp_q[$];
  logic        rd_strobe = 1'b0;

  int checks = 0;
  int errors = 0;

  // Monitor: samples just after the falling edge, well away from posedge.
  initial begin
    logic [11:0] got;
    logic [11:0] exp_w;
    int          exp_c;
    logic [7:0]  exp_r;
    forever begin
      @(negedge clk);
      #1;
      got = {calc_reset, calc_codigo, calc_entrada};
      checks++;
      if (busy === 1'b1) begin
        if (drive_q.size() == 0) begin
          errors++;
          $display("FAIL drive_unexpected cyc=%0d busy=1 got=%h want=no_playback", cyc, got);
        end else begin
          exp_w = drive_q.pop_front();
          if (got !== exp_w) begin
            errors++;
            $display("FAIL drive_word cyc=%0d got=%h want=%h", cyc, got, exp_w);
          end
        end
      end else if (busy !== 1'b0 || got !== IDLE_WORD) begin
        errors++;
        $display("FAIL idle_drive cyc=%0d busy=%b got=%h want=%h", cyc, busy, got, IDLE_WORD);
      end
      if (done !== 1'b0) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d got=%b want=0", cyc, done);
        end else begin
          exp_c = done_q.pop_front();
          if (cyc != exp_c) begin
            errors++;
            $display("FAIL done_cycle got=%0d want=%0d", cyc, exp_c);
          end
        end
      end
      if (rd_strobe) begin
        checks++;
        if (res_exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_queue addr=%0d got=%h want=entry", res_addr, res_data);
        end else begin
          exp_r = res_exp_q.pop_front();
          if (res_data !== exp_r) begin
            errors++;
            $display("FAIL result addr=%0d got=%h want=%h", res_addr, res_data, exp_r);
          end
        end
      end
    end
  end

  // All tasks are entered on a falling edge and return on a falling edge.
  task automatic write_prog(input int a, input logic [11:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    prog_model[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run(input int l);
    int n;
    n = (l > DEPTH) ? DEPTH : l;
    start = 1'b1;
    len   = (AW+1)'(l);
    for (int k = 0; k < n; k++) drive_q.push_back(prog_model[k]);
    if (n > 0) drive_q.push_back(IDLE_WORD);
    // Start edge happens at cyc+1; done follows it immediately for an empty
    // run, otherwise after n drive edges plus one drain edge.
    done_q.push_back(cyc + 1 + ((n == 0) ? 0 : n + 1));
    for (int k = 0; k < n; k++) begin
      res_model[k] = prog_model[k][7:0];
      res_known[k] = 1'b1;
    end
    $display("run len=%0d words=%0d at cyc=%0d", l, n, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    len   = '0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (done !== 1'b1 && i < 60) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout %s got=%b want=1", tag, done);
    end
  endtask

  task automatic readback();
    for (int a = 0; a < DEPTH; a++) begin
      if (res_known[a]) begin
        res_addr  = AW'(a);
        rd_strobe = 1'b1;
        res_exp_q.push_back(res_model[a]);
        @(negedge clk);
      end
    end
    rd_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) res_known[a] = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Fixed program from the reference example, random fill elsewhere.
    write_prog(0, 12'h800);
    write_prog(1, 12'h105);
    write_prog(2, 12'h203);
    for (int a = 3; a < DEPTH; a++) write_prog(a, 12'($urandom));

    run(3);
    wait_done("len3");
    readback();

    run(0);
    wait_done("len0");

    run(20);
    wait_done("len20");
    readback();

    // Asynchronous reset in the middle of a 5-word run.
    run(5);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_q.delete();
    done_q.delete();
    for (int k = 0; k < 5; k++) res_known[k] = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || {calc_reset, calc_codigo, calc_entrada} !== IDLE_WORD) begin
      errors++;
      $display("FAIL reset_immediate busy=%b got=%h want=%h", busy,
               {calc_reset, calc_codigo, calc_entrada}, IDLE_WORD);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run(5);
    wait_done("replay5");
    readback();

    // start/prog_we during playback are ignored; start on done is accepted.
    run(4);
    @(negedge clk);
    start     = 1'b1;
    len       = (AW+1)'(2);
    prog_we   = 1'b1;
    prog_addr = AW'(1);
    prog_data = ~prog_model[1];
    @(negedge clk);
    start   = 1'b0;
    len     = '0;
    prog_we = 1'b0;
    wait_done("busy_ignore");
    run(16);
    wait_done("back_to_back");
    readback();

    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < 3; j++) write_prog($urandom_range(0, DEPTH - 1), 12'($urandom));
      run($urandom_range(0, 20));
      wait_done("random");
      readback();
    end

    repeat (3) @(negedge clk);
    checks++;
    if (drive_q.size() != 0 || done_q.size() != 0 || res_exp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got=%0d/%0d/%0d want=0/0/0",
               drive_q.size(), done_q.size(), res_exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
